// File: rtl/scan_decoder_if.sv
// Bundles the control inputs and registered select outputs of scan_decoder.
interface scan_decoder_if #(
  parameter int unsigned ADDR_W = 2
);
  localparam int unsigned NUM_OUT = 1 << ADDR_W;

  logic              enable;
  logic              mode;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [NUM_OUT-1:0] out;
  logic [ADDR_W-1:0] cur_addr;
  logic              wrap;

  modport master (
    output enable, mode, load, address,
    input  out, cur_addr, wrap
  );

  modport slave (
    input  enable, mode, load, address,
    output out, cur_addr, wrap
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct-load and prescaled auto-scan modes.
// Optional SCAN_BLANK_EN: blanks out for the first cycle of each automatic scan step.
module scan_decoder #(
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned PRESCALE = 4
) (
  input logic          clk,
  input logic          reset_n,
  scan_decoder_if.slave bus
);
  localparam int unsigned NUM_OUT = 1 << ADDR_W;
  localparam int unsigned CNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = (PRESCALE >= 2);
`else
  localparam bit BLANK = 1'b0;
`endif

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic               mode_d_q, mode_d_d;
  logic [NUM_OUT-1:0] out_q, out_d;
  logic               wrap_q, wrap_d;
  logic               step;

  always_comb begin
    addr_d    = addr_q;
    pre_cnt_d = pre_cnt_q;
    mode_d_d  = bus.mode;
    wrap_d    = 1'b0;
    step      = 1'b0;
    out_d     = '0;

    // A mode change only restarts the prescaler; a load still takes priority.
    if (bus.load) begin
      addr_d    = bus.address;
      pre_cnt_d = '0;
    end else if (bus.mode != mode_d_q) begin
      pre_cnt_d = '0;
    end else if (bus.mode && bus.enable) begin
      if (pre_cnt_q == CNT_W'(PRESCALE - 1)) begin
        addr_d    = addr_q + 1'b1;
        pre_cnt_d = '0;
        step      = 1'b1;
        wrap_d    = (addr_q == '1);
      end else begin
        pre_cnt_d = pre_cnt_q + 1'b1;
      end
    end

    // out is computed from the address the register takes at this same edge.
    if (bus.enable && !(BLANK && step))
      out_d = NUM_OUT'(1) << addr_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      pre_cnt_q <= '0;
      mode_d_q  <= 1'b0;
      out_q     <= '0;
      wrap_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      pre_cnt_q <= pre_cnt_d;
      mode_d_q  <= mode_d_d;
      out_q     <= out_d;
      wrap_q    <= wrap_d;
    end
  end

  assign bus.out      = out_q;
  assign bus.cur_addr = addr_q;
  assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder with ADDR_W=2, PRESCALE=3.
module tb_scan_decoder;
  logic clk;
  logic reset_n;
  int unsigned n_checks;
  int unsigned n_pass;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  scan_decoder_if #(.ADDR_W(2)) bus ();

  scan_decoder #(
    .ADDR_W  (2),
    .PRESCALE(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_out;
    logic [3:0] one;
    int unsigned a;
    n_checks    = 0;
    n_pass      = 0;
    one         = 4'b0001;
    reset_n     = 1'b0;
    bus.enable  = 1'b0;
    bus.mode    = 1'b0;
    bus.load    = 1'b0;
    bus.address = 2'd0;

    repeat (2) tick();
    check("rst_out", 32'(bus.out), 32'h0);
    check("rst_cur", 32'(bus.cur_addr), 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    reset_n = 1'b1;

    // Direct load
    bus.load = 1'b1; bus.address = 2'd2; bus.enable = 1'b1;
    tick();
    check("ld2_out", 32'(bus.out), 32'h4);
    check("ld2_cur", 32'(bus.cur_addr), 32'h2);
    check("ld2_wrap", 32'(bus.wrap), 32'h0);

    // Enable gating in direct mode
    bus.address = 2'd3; bus.enable = 1'b0;
    tick();
    check("gate_out", 32'(bus.out), 32'h0);
    check("gate_cur", 32'(bus.cur_addr), 32'h3);
    bus.load = 1'b0; bus.enable = 1'b1;
    tick();
    check("reen_out", 32'(bus.out), 32'h8);
    tick();
    check("hold_out", 32'(bus.out), 32'h8);

    // Scan sweep from address 0 (load coincides with the mode change)
    bus.mode = 1'b1; bus.load = 1'b1; bus.address = 2'd0;
    tick();
    check("sw0_out", 32'(bus.out), 32'h1);
    bus.load = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      a = (e / 3) % 4;
      exp_out = one << a;
      if (BLANK && (e % 3 == 0)) exp_out = 4'b0000;
      check($sformatf("sw_out%0d", e), 32'(bus.out), 32'(exp_out));
      check($sformatf("sw_wrap%0d", e), 32'(bus.wrap), (e == 12) ? 32'h1 : 32'h0);
    end

    // Freeze with pre_cnt=1, then resume
    tick();
    check("pre1_out", 32'(bus.out), 32'h1);
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("frz_out%0d", i), 32'(bus.out), 32'h0);
      check($sformatf("frz_cur%0d", i), 32'(bus.cur_addr), 32'h0);
    end
    bus.enable = 1'b1;
    tick();
    check("res1_out", 32'(bus.out), 32'h1);
    tick();
    check("res2_cur", 32'(bus.cur_addr), 32'h1);
    check("res2_out", 32'(bus.out), BLANK ? 32'h0 : 32'h2);

    // Load on the cycle pre_cnt==2: no step, no wrap, prescaler restarts
    tick();
    tick();
    bus.load = 1'b1; bus.address = 2'd3;
    tick();
    check("lds_out", 32'(bus.out), 32'h8);
    check("lds_cur", 32'(bus.cur_addr), 32'h3);
    check("lds_wrap", 32'(bus.wrap), 32'h0);
    bus.load = 1'b0;
    tick();
    check("lds1_cur", 32'(bus.cur_addr), 32'h3);
    tick();
    check("lds2_cur", 32'(bus.cur_addr), 32'h3);
    tick();
    check("lds3_cur", 32'(bus.cur_addr), 32'h0);
    check("lds3_wrap", 32'(bus.wrap), 32'h1);

    // Mode toggles restart the prescaler without stepping
    tick();
    tick();
    bus.mode = 1'b0;
    tick();
    check("tog0_cur", 32'(bus.cur_addr), 32'h0);
    check("tog0_out", 32'(bus.out), 32'h1);
    bus.mode = 1'b1;
    tick();
    check("tog1_cur", 32'(bus.cur_addr), 32'h0);
    tick();
    tick();
    check("tog3_cur", 32'(bus.cur_addr), 32'h0);
    tick();
    check("tog4_cur", 32'(bus.cur_addr), 32'h1);

    // Asynchronous reset mid-scan
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", 32'(bus.out), 32'h0);
    check("arst_cur", 32'(bus.cur_addr), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_out", 32'(bus.out), 32'h1);
    check("post_rst_cur", 32'(bus.cur_addr), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
